uart_rx: RTL and testbench
==========================

# uart_rx

Serial console receiver: the input-direction counterpart of the CPU's 9-bit `{valid, data}` console output port. Recovers 8N1 bytes from a serial `rx` line, buffers them, and presents them to the RV32IM core as a 9-bit `{valid, data}` word that the core consumes with a one-cycle read strobe. Sits between the board/testbench serial source and the core's memory-mapped console-input register.

## Interface
- `CLKS_PER_BIT`, 8: clock cycles per serial bit; even, ≥ 4.
- `FIFO_DEPTH`, 4: receive buffer entries; power of two, ≥ 2. Used only with `UART_RX_FIFO_EN`.
- `clock`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial input; idles high; asynchronous to `clock`.
- `rd`  in  1  pop strobe from the core; one byte consumed per cycle high.
- `err_clr`  in  1  clears the sticky error flags.
- `uart_in`  out  9  `{valid, data[7:0]}`; `valid` = buffer non-empty, `data` = oldest byte, 8'h00 when empty.
- `ferr`  out  1  sticky framing error (stop bit sampled low).
- `ovr`  out  1  sticky overrun (byte completed while buffer full).
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, STOP. One bit-timer counter (0..CLKS_PER_BIT-1) and one 3-bit bit index.
- IDLE: on `rxs` = 0 go to START, timer cleared.
- START: after CLKS_PER_BIT/2 cycles sample `rxs`. If 1 (glitch) return to IDLE with no flags set; if 0 go to DATA, timer cleared.
- DATA: every CLKS_PER_BIT cycles sample `rxs` into the shift register, LSB first. After bit 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles sample `rxs`. If 1, push the byte. If 0, drop the byte and set `ferr`. Either way return to IDLE. A low stop bit is not reinterpreted as a new start bit; IDLE waits for the next high-to-low edge seen as `rxs` = 0.
- Push into a full buffer: byte dropped, `ovr` set, buffer contents unchanged.
- Pop: `rd` high with `valid` = 1 removes the head at that edge. `rd` while empty is ignored.
- Push and pop in the same cycle: the pop happens first, so the push always succeeds with no `ovr`, even when full. Occupancy is unchanged.
- `err_clr` clears `ferr` and `ovr`. An error event in the same cycle as `err_clr` wins, so the flag stays set.

## Timing
- Reset values: FSM IDLE, buffer empty, `uart_in` = 9'h000, `ferr` = 0, `ovr` = 0, `busy` = 0, synchronizer = 1.
- Reset asserted mid-frame aborts the frame. No partial byte is ever pushed.
- Latency: the stop-bit sample edge pushes the byte. `uart_in` shows it (valid = 1) from the next cycle.
- Total from the `rx` falling edge to valid: 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles, which is 79 at the default.
- `uart_in` is registered/FIFO-head combinational. It updates the cycle after a pop.
- Back-to-back frames are supported with a single stop bit. IDLE re-arms in the cycle after the stop sample.

## Configuration
- `UART_RX_FIFO_EN` defined: circular buffer of FIFO_DEPTH entries, with read/write pointers one bit wider than the index. Full when the pointer MSBs differ and the index bits are equal.
- `UART_RX_FIFO_EN` undefined: single holding register, effective depth 1. Full = `valid`. The same-cycle push/pop rule still applies. `FIFO_DEPTH` is ignored.

## Structure
- Shared package `uart_pkg`: FSM state encoding (IDLE/START/DATA/STOP), `UART_DATA_W` = 8, `UART_WORD_W` = 9. The package is reused by the output-side console model.
- One sub-module, `uart_rx_fifo`: push/pop/full/empty/head, covering both `UART_RX_FIFO_EN` variants. Synchronizer, FSM and error flags stay in `uart_rx`.

## Test plan
- Single byte: drive 0x41 8N1 at CLKS_PER_BIT = 8 → `uart_in` = 9'h141 exactly 79 cycles after the `rx` fall; `rd` pulse → 9'h000 next cycle.
- Glitch: `rx` low for 2 cycles, then high → FSM returns to IDLE, no byte, `ferr` = 0.
- Framing: send 0x55 with stop bit low → no byte pushed, `ferr` = 1; `err_clr` → `ferr` = 0.
- Overrun (FIFO enabled, depth 4): send 0x01..0x05 without `rd` → `ovr` = 1; pops return 0x01, 0x02, 0x03, 0x04, then empty.
- Full plus simultaneous pop: with 4 bytes held, assert `rd` in the cycle the stop bit of 0x99 is sampled → `ovr` = 0; the last entry read is 0x99.
- Reset mid-frame: assert `reset` during DATA bit 4 of 0xA5 → all outputs at reset values; the next clean frame 0x3C → 9'h13C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared console-UART definitions: receiver FSM state encoding and the
// data/word widths of the 9-bit {valid, data} console port. The
// output-side console model imports this package too.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_WORD_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer for uart_rx.
// With UART_RX_FIFO_EN defined this is a FIFO_DEPTH-entry circular buffer.
// Otherwise it is a single holding register (effective depth 1).
// In both builds a pop is applied before a push in the same cycle, so a
// push into a full buffer still succeeds when the head is being consumed.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [UART_DATA_W-1:0] i_pushData,
    input  logic                   i_pop,
    output logic                   o_empty,
    output logic [UART_DATA_W-1:0] o_head,
    output logic                   o_drop
);

    logic w_empty;
    logic w_full;
    logic w_doPop;
    logic w_doPush;

    assign w_doPop  = i_pop && !w_empty;
    assign w_doPush = i_push && (!w_full || w_doPop);
    assign o_drop   = i_push && !w_doPush;
    assign o_empty  = w_empty;

`ifdef UART_RX_FIFO_EN

    localparam int IDX_W = $clog2(FIFO_DEPTH);

    logic [IDX_W:0]           r_wrPtr;
    logic [IDX_W:0]           r_rdPtr;
    logic [UART_DATA_W-1:0]   r_mem [FIFO_DEPTH];

    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[IDX_W] != r_rdPtr[IDX_W]) &&
                     (r_wrPtr[IDX_W-1:0] == r_rdPtr[IDX_W-1:0]);
    assign o_head  = w_empty ? '0 : r_mem[r_rdPtr[IDX_W-1:0]];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers decide what is visible.
    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[IDX_W-1:0]] <= i_pushData;
        end
    end

`else

    logic                     r_valid;
    logic [UART_DATA_W-1:0]   r_data;

    assign w_empty = !r_valid;
    assign w_full  = r_valid;
    assign o_head  = r_data;

    // The depth parameter has no meaning for the single holding register.
    if (FIFO_DEPTH < 2) begin : g_depthIgnored
    end

    // Holding register; data is zeroed whenever it empties so the head reads 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_doPush) begin
            r_valid <= 1'b1;
            r_data  <= i_pushData;
        end else if (w_doPop) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end
    end

`endif

endmodule

// File: rtl/uart_rx.sv
// Serial console receiver: recovers 8N1 bytes from rx and presents them to
// the core as a 9-bit {valid, data} word, consumed with a one-cycle rd strobe.
// Optional build macro: UART_RX_FIFO_EN selects a FIFO_DEPTH-entry buffer
// instead of the single holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   rd,
    input  logic                   err_clr,
    output logic [UART_WORD_W-1:0] uart_in,
    output logic                   ferr,
    output logic                   ovr,
    output logic                   busy
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);

    logic                   r_rxSync1;
    logic                   r_rxs;
    logic                   r_rxsPrev;
    uart_state_t            r_state;
    logic [TIMER_W-1:0]     r_timer;
    logic [2:0]             r_bitIdx;
    logic [UART_DATA_W-1:0] r_shift;
    logic                   r_ferr;
    logic                   r_ovr;

    logic                   w_stopSample;
    logic                   w_push;
    logic                   w_ferrEvent;
    logic                   w_drop;
    logic                   w_empty;
    logic [UART_DATA_W-1:0] w_head;

    // A good stop bit pushes the byte on the very edge it is sampled.
    assign w_stopSample = (r_state == ST_STOP) && (r_timer == BIT_LAST);
    assign w_push       = w_stopSample && r_rxs;
    assign w_ferrEvent  = w_stopSample && !r_rxs;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection;
    // all idle-high so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rxSync1 <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxsPrev <= 1'b1;
        end else begin
            r_rxSync1 <= rx;
            r_rxs     <= r_rxSync1;
            r_rxsPrev <= r_rxs;
        end
    end

    // Frame FSM: IDLE only leaves on a high-to-low edge, so a low stop bit
    // that lingers is never taken as the next start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timer  <= '0;
                    r_bitIdx <= '0;
                    if (!r_rxs && r_rxsPrev) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_timer == HALF_LAST) begin
                        r_timer <= '0;
                        r_state <= r_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_timer == BIT_LAST) begin
                        r_timer <= '0;
                        r_shift <= {r_rxs, r_shift[UART_DATA_W-1:1]};
                        if (r_bitIdx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_timer == BIT_LAST) begin
                        r_timer <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new error event outranks a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_ferrEvent) begin
                r_ferr <= 1'b1;
            end else if (err_clr) begin
                r_ferr <= 1'b0;
            end
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (err_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_push),
        .i_pushData (r_shift),
        .i_pop      (rd),
        .o_empty    (w_empty),
        .o_head     (w_head),
        .o_drop     (w_drop)
    );

    assign uart_in = {!w_empty, w_head};
    assign ferr    = r_ferr;
    assign ovr     = r_ovr;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed 8N1 frames with a scoreboard queue of
// expected popped words and a monitor that checks every pop.
module tb_uart_rx;

    localparam int CPB = 8;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd;
    logic       err_clr;
    logic [8:0] uart_in;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int         compared   = 0;
    int         mismatched = 0;
    logic [8:0] expQ[$];
    logic [8:0] monExp;
    logic [8:0] lastPopped = 9'h000;
    logic       expOvr = 1'b0;
    logic       expFerr = 1'b0;

    always #5 clock = ~clock;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rx      (rx),
        .rd      (rd),
        .err_clr (err_clr),
        .uart_in (uart_in),
        .ferr    (ferr),
        .ovr     (ovr),
        .busy    (busy)
    );

    task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic waitEdge();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every accepted pop is compared against the oldest expected word.
    always @(negedge clock) begin
        if (!reset && rd) begin
            if (uart_in[8]) begin
                lastPopped = uart_in;
                if (expQ.size() == 0) begin
                    checkOutput("popUnexpected", uart_in, 9'h000);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("popData", uart_in, monExp);
                end
            end else if (expQ.size() != 0) begin
                monExp = expQ.pop_front();
                checkOutput("popMissing", uart_in, monExp);
            end
        end
    end

    // Sends one frame; optionally pops at the stop-sample edge, checks the
    // 79-cycle latency, or aborts with reset in the middle of bit abortBit.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input bit popAtStop, input bit checkLat,
                                 input int abortBit);
        logic [9:0] bits;
        int n;
        bits = {stopBit, data, 1'b0};
        n = 0;
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            if (b == abortBit) begin
                repeat (CPB / 2) waitEdge();
                checkOutput("busyMidFrame", {8'h00, busy}, 9'h001);
                reset = 1'b1;
                rx = 1'b1;
                return;
            end
            for (int c = 0; c < CPB; c++) begin
                waitEdge();
                n++;
                if (popAtStop && n == 78) rd = 1'b1;
                if (popAtStop && n == 79) rd = 1'b0;
                if (checkLat && n == 78) checkOutput("latencyEarly", uart_in, 9'h000);
                if (checkLat && n == 79) checkOutput("latency79", uart_in, {1'b1, data});
            end
        end
        rx = 1'b1;
        if (stopBit) begin
            if (expQ.size() < DEPTH) expQ.push_back({1'b1, data});
            else expOvr = 1'b1;
        end else begin
            expFerr = 1'b1;
        end
    endtask

    task automatic popOne();
        rd = 1'b1;
        waitEdge();
        rd = 1'b0;
    endtask

    task automatic pulseErrClr();
        err_clr = 1'b1;
        waitEdge();
        err_clr = 1'b0;
        expOvr = 1'b0;
        expFerr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rx = 1'b1;
        rd = 1'b0;
        err_clr = 1'b0;
        reset = 1'b1;
        repeat (3) waitEdge();
        reset = 1'b0;
        waitEdge();
        checkOutput("resetUartIn", uart_in, 9'h000);
        checkOutput("resetFerr", {8'h00, ferr}, 9'h000);
        checkOutput("resetOvr", {8'h00, ovr}, 9'h000);
        checkOutput("resetBusy", {8'h00, busy}, 9'h000);

        $display("[TB] single byte 0x41");
        applyStimulus(8'h41, 1'b1, 1'b0, 1'b1, -1);
        popOne();
        checkOutput("afterPop", uart_in, 9'h000);

        $display("[TB] start-bit glitch");
        rx = 1'b0;
        repeat (2) waitEdge();
        rx = 1'b1;
        repeat (2) waitEdge();
        checkOutput("glitchBusy", {8'h00, busy}, 9'h001);
        repeat (20) waitEdge();
        checkOutput("glitchIdle", {8'h00, busy}, 9'h000);
        checkOutput("glitchNoByte", uart_in, 9'h000);
        checkOutput("glitchFerr", {8'h00, ferr}, 9'h000);

        $display("[TB] framing error on 0x55");
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, -1);
        repeat (4) waitEdge();
        checkOutput("framingFerr", {8'h00, ferr}, 9'h001);
        checkOutput("framingNoByte", uart_in, 9'h000);
        checkOutput("framingNoRestart", {8'h00, busy}, 9'h000);
        pulseErrClr();
        checkOutput("ferrCleared", {8'h00, ferr}, 9'h000);

        $display("[TB] overrun with 0x01..0x05");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1, 1'b0, 1'b0, -1);
        end
        waitEdge();
        checkOutput("overrunOvr", {8'h00, ovr}, {8'h00, expOvr});
        checkOutput("overrunFerr", {8'h00, ferr}, 9'h000);
        while (expQ.size() > 0) popOne();
        checkOutput("overrunDrained", uart_in, 9'h000);
        pulseErrClr();
        checkOutput("ovrCleared", {8'h00, ovr}, 9'h000);

        $display("[TB] full buffer with pop at stop sample");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, -1);
        end
        applyStimulus(8'h99, 1'b1, 1'b1, 1'b0, -1);
        waitEdge();
        checkOutput("fullPopOvr", {8'h00, ovr}, 9'h000);
        while (expQ.size() > 0) popOne();
        checkOutput("fullPopLast", lastPopped, 9'h199);
        checkOutput("fullPopDrained", uart_in, 9'h000);

        $display("[TB] reset during data bit 4 of 0xA5");
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 5);
        waitEdge();
        checkOutput("midResetUartIn", uart_in, 9'h000);
        checkOutput("midResetBusy", {8'h00, busy}, 9'h000);
        checkOutput("midResetFerr", {8'h00, ferr}, 9'h000);
        checkOutput("midResetOvr", {8'h00, ovr}, 9'h000);
        reset = 1'b0;
        expQ.delete();
        repeat (4) waitEdge();
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, -1);
        popOne();
        checkOutput("afterResetFrameDrained", uart_in, 9'h000);

        repeat (4) waitEdge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
